// File: rtl/spwm_pkg.sv
// Shared types and default widths for the SPWM sequencer.
package spwm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POS_RISE,
    POS_FALL,
    NEG_RISE,
    NEG_FALL
  } spwm_state_t;

  localparam int unsigned SPWM_CARRIER_W   = 10;
  localparam int unsigned SPWM_ADDR_W      = 8;
  localparam int unsigned SPWM_DIV_W       = 16;
  localparam int unsigned SPWM_CARRIER_MAX = 1023;

endpackage

// File: rtl/spwm_carrier_gen.sv
// Prescaled triangle carrier; valley_c flags the tick that brings a down ramp to 0.
module spwm_carrier_gen
  import spwm_pkg::*;
#(
  parameter int unsigned CARRIER_W   = SPWM_CARRIER_W,
  parameter int unsigned CARRIER_MAX = SPWM_CARRIER_MAX,
  parameter int unsigned DIV_W       = SPWM_DIV_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_W-1:0]     div,
  output logic [CARRIER_W-1:0] carrier,
  output logic                 valley_c
);

  localparam logic [CARRIER_W-1:0] PEAK = CARRIER_W'(CARRIER_MAX);

  logic [DIV_W-1:0] presc;
  logic             dir_up;
  logic             tick_c;

  // >= so a lowered divider wraps at the next compare instead of overrunning
  assign tick_c   = en && (presc >= div);
  assign valley_c = tick_c && !dir_up && (carrier == CARRIER_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      carrier <= '0;
      dir_up  <= 1'b1;
    end else if (!en) begin
      presc   <= '0;
      carrier <= '0;
      dir_up  <= 1'b1;
    end else begin
      presc <= tick_c ? '0 : presc + DIV_W'(1);
      if (tick_c) begin
        if (dir_up) begin
          carrier <= carrier + CARRIER_W'(1);
          if (carrier == PEAK - CARRIER_W'(1)) dir_up <= 1'b0;
        end else begin
          carrier <= carrier - CARRIER_W'(1);
          if (carrier == CARRIER_W'(1)) dir_up <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spwm_sequencer.sv
// SPWM sequencer: carrier, quarter-wave address and half-cycle enables.
// Optional SPWM_SYNC_UPDATE_EN: carrier_div only takes effect at sine-cycle boundaries.
module spwm_sequencer
  import spwm_pkg::*;
#(
  parameter int unsigned CARRIER_W   = SPWM_CARRIER_W,
  parameter int unsigned CARRIER_MAX = SPWM_CARRIER_MAX,
  parameter int unsigned ADDR_W      = SPWM_ADDR_W,
  parameter int unsigned DIV_W       = SPWM_DIV_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_W-1:0]     carrier_div,
  output logic [CARRIER_W-1:0] carrier,
  output logic [ADDR_W-1:0]    sine_addr,
  output logic                 en_inc,
  output logic                 en_dec,
  output logic                 modo_signal,
  output logic                 sample_strobe,
  output logic                 cycle_done,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  spwm_state_t      state;
  logic             stop_latch;
  logic             valley_c;
  logic             wrap_c;
  logic [DIV_W-1:0] div_eff;

  assign wrap_c = valley_c && (state == NEG_FALL) && (sine_addr == ADDR_W'(1));

`ifdef SPWM_SYNC_UPDATE_EN
  logic [DIV_W-1:0] div_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_shadow <= '0;
    else if (((state == IDLE) && start) || wrap_c)
      div_shadow <= carrier_div;
  end

  assign div_eff = div_shadow;
`else
  assign div_eff = carrier_div;
`endif

  spwm_carrier_gen #(
    .CARRIER_W   (CARRIER_W),
    .CARRIER_MAX (CARRIER_MAX),
    .DIV_W       (DIV_W)
  ) u_carrier (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .div      (div_eff),
    .carrier  (carrier),
    .valley_c (valley_c)
  );

  // Outputs are updated alongside each state transition so they stay registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      stop_latch    <= 1'b0;
      sine_addr     <= '0;
      en_inc        <= 1'b0;
      en_dec        <= 1'b0;
      modo_signal   <= 1'b0;
      sample_strobe <= 1'b0;
      cycle_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sample_strobe <= valley_c;
      cycle_done    <= wrap_c;
      if ((state != IDLE) && stop) stop_latch <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= POS_RISE;
            stop_latch  <= stop;
            sine_addr   <= '0;
            busy        <= 1'b1;
            en_inc      <= 1'b1;
            modo_signal <= 1'b1;
          end
        end
        POS_RISE, NEG_RISE: begin
          if (valley_c) begin
            if (sine_addr == ADDR_MAX) begin
              state     <= (state == POS_RISE) ? POS_FALL : NEG_FALL;
              sine_addr <= ADDR_MAX - ADDR_W'(1);
            end else begin
              sine_addr <= sine_addr + ADDR_W'(1);
            end
          end
        end
        POS_FALL: begin
          if (valley_c) begin
            if (sine_addr == ADDR_W'(1)) begin
              state       <= NEG_RISE;
              sine_addr   <= '0;
              en_inc      <= 1'b0;
              en_dec      <= 1'b1;
              modo_signal <= 1'b0;
            end else begin
              sine_addr <= sine_addr - ADDR_W'(1);
            end
          end
        end
        NEG_FALL: begin
          if (valley_c) begin
            if (sine_addr == ADDR_W'(1)) begin
              sine_addr <= '0;
              en_dec    <= 1'b0;
              if (stop_latch) begin
                state      <= IDLE;
                stop_latch <= 1'b0;
                busy       <= 1'b0;
              end else begin
                state       <= POS_RISE;
                en_inc      <= 1'b1;
                modo_signal <= 1'b1;
              end
            end else begin
              sine_addr <= sine_addr - ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spwm_sequencer.sv
// Directed bench for spwm_sequencer with CARRIER_MAX=4, ADDR_W=2.
module tb_spwm_sequencer;

  localparam int unsigned CW = 10;
  localparam int unsigned CM = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [DW-1:0] carrier_div;
  logic [CW-1:0] carrier;
  logic [AW-1:0] sine_addr;
  logic          en_inc;
  logic          en_dec;
  logic          modo_signal;
  logic          sample_strobe;
  logic          cycle_done;
  logic          busy;

  int checks;
  int errors;
  int addr_tbl [12];
  int times [16];
  int ns;

  spwm_sequencer #(
    .CARRIER_W   (CW),
    .CARRIER_MAX (CM),
    .ADDR_W      (AW),
    .DIV_W       (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .carrier_div   (carrier_div),
    .carrier       (carrier),
    .sine_addr     (sine_addr),
    .en_inc        (en_inc),
    .en_dec        (en_dec),
    .modo_signal   (modo_signal),
    .sample_strobe (sample_strobe),
    .cycle_done    (cycle_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},    32'(busy),          32'd0);
    chk({tag, ".en_inc"},  32'(en_inc),        32'd0);
    chk({tag, ".en_dec"},  32'(en_dec),        32'd0);
    chk({tag, ".modo"},    32'(modo_signal),   32'd0);
    chk({tag, ".strobe"},  32'(sample_strobe), 32'd0);
    chk({tag, ".done"},    32'(cycle_done),    32'd0);
    chk({tag, ".carrier"}, 32'(carrier),       32'd0);
    chk({tag, ".addr"},    32'(sine_addr),     32'd0);
  endtask

  function automatic int tri_val(input int p);
    return (p <= 4) ? p : 8 - p;
  endfunction

  // k = clocks since the edge that sampled start (k=1 is that edge); div=0 timing
  task automatic chk_run(input int k, input int end_k);
    int n;
    int m;
    int p;
    int s;
    if (end_k != 0 && k > end_k) begin
      chk_idle("after_stop");
      return;
    end
    if (k == end_k) begin
      chk("end.busy",    32'(busy),          32'd0);
      chk("end.en_inc",  32'(en_inc),        32'd0);
      chk("end.en_dec",  32'(en_dec),        32'd0);
      chk("end.modo",    32'(modo_signal),   32'd0);
      chk("end.carrier", 32'(carrier),       32'd0);
      chk("end.addr",    32'(sine_addr),     32'd0);
      chk("end.strobe",  32'(sample_strobe), 32'd1);
      chk("end.done",    32'(cycle_done),    32'd1);
      return;
    end
    n = (k - 1) / 8;
    m = n % 12;
    p = (k - 1) % 8;
    s = (k > 1 && p == 0) ? 1 : 0;
    chk("run.carrier", 32'(carrier),       32'(tri_val(p)));
    chk("run.addr",    32'(sine_addr),     32'(addr_tbl[m]));
    chk("run.strobe",  32'(sample_strobe), 32'(s));
    chk("run.done",    32'(cycle_done),    32'((s == 1 && m == 0) ? 1 : 0));
    chk("run.en_inc",  32'(en_inc),        32'((m < 6) ? 1 : 0));
    chk("run.en_dec",  32'(en_dec),        32'((m >= 6) ? 1 : 0));
    chk("run.modo",    32'(modo_signal),   32'((m < 6) ? 1 : 0));
    chk("run.busy",    32'(busy),          32'd1);
    chk("run.excl",    32'(en_inc & en_dec), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    addr_tbl = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1};
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    carrier_div = '0;
    ns = 0;
    for (int i = 0; i < 16; i++) times[i] = 0;

    // Reset state, then 20 idle cycles; a stop pulse in IDLE must not latch
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("idle");
      stop = (i == 5);
    end
    stop = 1'b0;

    // Free run with div=0, stop pulsed mid POS_FALL of the second cycle
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      chk_run(k, 193);
      start = 1'b0;
      stop = (k == 132);
    end
    stop = 1'b0;

    // Restart, then asynchronous reset in NEG_RISE
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      chk_run(k, 0);
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk_run(k, 0);
      start = 1'b0;
    end

    // Divider change mid-cycle: div 1 -> 3
    do_reset();
    carrier_div = DW'(1);
    start = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sample_strobe && ns < 16) begin
        times[ns] = k;
        ns++;
      end
      if (k == 20) carrier_div = DW'(3);
    end
    chk("div.first_valley", 32'(times[0]), 32'd17);
`ifdef SPWM_SYNC_UPDATE_EN
    chk("div.pre_period",   32'(times[10] - times[9]), 32'd16);
    chk("div.boundary",     32'(times[11]), 32'd193);
    chk("div.post_period",  32'(times[12] - times[11]), 32'd32);
`else
    chk("div.live_period",  32'(times[2] - times[1]), 32'd32);
    chk("div.live_period2", 32'(times[3] - times[2]), 32'd32);
`endif

    // start and stop together: exactly one cycle
    do_reset();
    carrier_div = '0;
    start = 1'b1;
    stop = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk_run(k, 97);
      start = 1'b0;
      stop = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
